// File: rtl/bcd_updown_cnt_n.sv
// bcd_updown_cnt_n: parametrised multi-digit BCD up/down counter with
// synchronous load, wrap/saturate mode and a registered terminal-count flag.
// Digit 0 is the least significant digit and occupies cnt[3:0].
// Optional build macro: BCD_CNT_CLAMP_EN. When defined, init nibbles above 9
// are stored as 9 on reset/load. When undefined, init is stored raw and any
// out-of-range digit is forced to 0 on the next enabled step.
module bcd_updown_cnt_n #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   init,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  zero,
    output logic [DIGITS-1:0]     digit_zero,
    output logic                  tc
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam logic [3:0]  NINE = 4'd9;

    logic [W-1:0]      r_cnt;
    logic              r_tc;

    logic [W-1:0]      w_init_val;
    logic [W-1:0]      w_step_val;
    logic [W-1:0]      w_next;
    logic              w_all_zero;
    logic              w_all_nine;
    logic              w_at_term;
    logic [DIGITS-1:0] w_digit_zero;

    // Value written on reset and load; out-of-range nibbles optionally clamped to 9
    always_comb begin : init_sel
        w_init_val = init;
`ifdef BCD_CNT_CLAMP_EN
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (init[4*i +: 4] > NINE) begin
                w_init_val[4*i +: 4] = NINE;
            end
        end
`endif
    end

    // Per-digit zero flags and the all-zero / all-nine terminal detectors
    always_comb begin : term_detect
        w_all_nine   = 1'b1;
        w_digit_zero = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_digit_zero[i] = (r_cnt[4*i +: 4] == 4'd0);
            if (r_cnt[4*i +: 4] != NINE) begin
                w_all_nine = 1'b0;
            end
        end
        w_all_zero = (r_cnt == '0);
        w_at_term  = up ? w_all_nine : w_all_zero;
    end

    // One decimal step with ripple carry/borrow; invalid digits reset to 0 and break the chain
    always_comb begin : step_calc
        logic       v_chain;
        logic       v_valid;
        logic [3:0] v_nib;
        w_step_val = r_cnt;
        v_chain    = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            v_nib = r_cnt[4*i +: 4];
`ifdef BCD_CNT_CLAMP_EN
            v_valid = 1'b1;
`else
            v_valid = (v_nib <= NINE);
`endif
            if (!v_valid) begin
                w_step_val[4*i +: 4] = 4'd0;
            end else if (v_chain) begin
                if (up) begin
                    w_step_val[4*i +: 4] = (v_nib == NINE) ? 4'd0 : 4'(v_nib + 4'd1);
                end else begin
                    w_step_val[4*i +: 4] = (v_nib == 4'd0) ? NINE : 4'(v_nib - 4'd1);
                end
            end else begin
                w_step_val[4*i +: 4] = v_nib;
            end
            v_chain = v_chain & v_valid & (up ? (v_nib == NINE) : (v_nib == 4'd0));
        end
    end

    // Saturating mode suppresses the step when already at the terminal value
    always_comb begin : next_sel
        w_next = w_step_val;
        if ((WRAP == 0) && w_at_term) begin
            w_next = r_cnt;
        end
    end

    // Count and terminal-count registers; priority reset > load > enable > hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= w_init_val;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_cnt <= w_init_val;
            r_tc  <= 1'b0;
        end else if (en) begin
            r_cnt <= w_next;
            r_tc  <= w_at_term;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign cnt        = r_cnt;
    assign tc         = r_tc;
    assign zero       = w_all_zero;
    assign digit_zero = w_digit_zero;

endmodule

// File: tb/tb_bcd_updown_cnt_n.sv
// Directed testbench for bcd_updown_cnt_n. Three instances cover
// DIGITS=2/WRAP=1, DIGITS=3/WRAP=1 and DIGITS=2/WRAP=0. Expectations for the
// out-of-range init case follow the BCD_CNT_CLAMP_EN build macro.
module tb_bcd_updown_cnt_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: 2 digits, wrapping
    logic       a_rst_n, a_en, a_up, a_load;
    logic [7:0] a_init, a_cnt;
    logic       a_zero, a_tc;
    logic [1:0] a_dz;

    // Instance B: 3 digits, wrapping
    logic        b_rst_n, b_en, b_up, b_load;
    logic [11:0] b_init, b_cnt;
    logic        b_zero, b_tc;
    logic [2:0]  b_dz;

    // Instance C: 2 digits, saturating
    logic       c_rst_n, c_en, c_up, c_load;
    logic [7:0] c_init, c_cnt;
    logic       c_zero, c_tc;
    logic [1:0] c_dz;

    bcd_updown_cnt_n #(.DIGITS(2), .WRAP(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .up(a_up), .load(a_load),
        .init(a_init), .cnt(a_cnt), .zero(a_zero), .digit_zero(a_dz), .tc(a_tc));

    bcd_updown_cnt_n #(.DIGITS(3), .WRAP(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .up(b_up), .load(b_load),
        .init(b_init), .cnt(b_cnt), .zero(b_zero), .digit_zero(b_dz), .tc(b_tc));

    bcd_updown_cnt_n #(.DIGITS(2), .WRAP(0)) u_c (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .up(c_up), .load(c_load),
        .init(c_init), .cnt(c_cnt), .zero(c_zero), .digit_zero(c_dz), .tc(c_tc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset loads init and clears tc, then down count wraps 00 -> 99 with a tc pulse
    task automatic test_reset();
        a_init = 8'h03; a_rst_n = 1'b0; a_en = 1'b1; a_up = 1'b0; a_load = 1'b0;
        tick();
        n_total++; if (a_cnt !== 8'h03) $display("FAIL reset_cnt got %h exp 03", a_cnt); else n_pass++;
        n_total++; if (a_tc !== 1'b0) $display("FAIL reset_tc got %b exp 0", a_tc); else n_pass++;
        a_rst_n = 1'b1;
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_cnt [4];
        logic       exp_tc  [4];
        exp_cnt = '{8'h02, 8'h01, 8'h00, 8'h99};
        exp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (a_cnt !== exp_cnt[i]) $display("FAIL down_wrap_cnt[%0d] got %h exp %h", i, a_cnt, exp_cnt[i]); else n_pass++;
            n_total++; if (a_tc !== exp_tc[i]) $display("FAIL down_wrap_tc[%0d] got %b exp %b", i, a_tc, exp_tc[i]); else n_pass++;
            if (i == 2) begin
                n_total++; if (a_zero !== 1'b1) $display("FAIL down_wrap_zero got %b exp 1", a_zero); else n_pass++;
            end
        end
        tick();
        n_total++; if (a_cnt !== 8'h98) $display("FAIL down_after_wrap_cnt got %h exp 98", a_cnt); else n_pass++;
        n_total++; if (a_tc !== 1'b0) $display("FAIL down_after_wrap_tc got %b exp 0", a_tc); else n_pass++;
        a_en = 1'b0;
    endtask

    // Three-digit carry ripple and up wrap 999 -> 000
    task automatic test_up_carry();
        b_load = 1'b1; b_init = 12'h199; b_en = 1'b0; b_up = 1'b1;
        tick();
        n_total++; if (b_cnt !== 12'h199) $display("FAIL carry_load got %h exp 199", b_cnt); else n_pass++;
        b_load = 1'b0; b_en = 1'b1;
        tick();
        n_total++; if (b_cnt !== 12'h200) $display("FAIL carry_cnt got %h exp 200", b_cnt); else n_pass++;
        n_total++; if (b_tc !== 1'b0) $display("FAIL carry_tc got %b exp 0", b_tc); else n_pass++;
        b_load = 1'b1; b_init = 12'h999;
        tick();
        b_load = 1'b0;
        tick();
        n_total++; if (b_cnt !== 12'h000) $display("FAIL up_wrap_cnt got %h exp 000", b_cnt); else n_pass++;
        n_total++; if (b_tc !== 1'b1) $display("FAIL up_wrap_tc got %b exp 1", b_tc); else n_pass++;
        n_total++; if (b_dz !== 3'b111) $display("FAIL up_wrap_dz got %b exp 111", b_dz); else n_pass++;
        tick();
        n_total++; if (b_cnt !== 12'h001) $display("FAIL up_after_wrap_cnt got %h exp 001", b_cnt); else n_pass++;
        n_total++; if (b_tc !== 1'b0) $display("FAIL up_after_wrap_tc got %b exp 0", b_tc); else n_pass++;
        b_en = 1'b0;
    endtask

    // Saturating mode holds at 00 / 99 with tc high while enabled
    task automatic test_saturate();
        logic       exp_tc [3];
        exp_tc = '{1'b0, 1'b1, 1'b1};
        c_load = 1'b1; c_init = 8'h01; c_en = 1'b0; c_up = 1'b0;
        tick();
        c_load = 1'b0; c_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (c_cnt !== 8'h00) $display("FAIL sat_down_cnt[%0d] got %h exp 00", i, c_cnt); else n_pass++;
            n_total++; if (c_tc !== exp_tc[i]) $display("FAIL sat_down_tc[%0d] got %b exp %b", i, c_tc, exp_tc[i]); else n_pass++;
        end
        n_total++; if (c_zero !== 1'b1) $display("FAIL sat_zero got %b exp 1", c_zero); else n_pass++;
        c_en = 1'b0;
        tick();
        n_total++; if (c_tc !== 1'b0) $display("FAIL sat_hold_tc got %b exp 0", c_tc); else n_pass++;
        c_load = 1'b1; c_init = 8'h98; c_up = 1'b1;
        tick();
        c_load = 1'b0; c_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (c_cnt !== 8'h99) $display("FAIL sat_up_cnt[%0d] got %h exp 99", i, c_cnt); else n_pass++;
            n_total++; if (c_tc !== exp_tc[i]) $display("FAIL sat_up_tc[%0d] got %b exp %b", i, c_tc, exp_tc[i]); else n_pass++;
        end
        c_en = 1'b0;
    endtask

    // Load beats enable; reset beats load and a pending terminal step
    task automatic test_priority();
        a_load = 1'b1; a_init = 8'h50; a_en = 1'b0;
        tick();
        a_init = 8'h27; a_en = 1'b1; a_up = 1'b0;
        tick();
        n_total++; if (a_cnt !== 8'h27) $display("FAIL load_wins_cnt got %h exp 27", a_cnt); else n_pass++;
        n_total++; if (a_tc !== 1'b0) $display("FAIL load_wins_tc got %b exp 0", a_tc); else n_pass++;
        a_init = 8'h00; a_en = 1'b0;
        tick();
        a_load = 1'b0; a_en = 1'b1; a_rst_n = 1'b0; a_init = 8'h45;
        tick();
        n_total++; if (a_cnt !== 8'h45) $display("FAIL reset_wins_cnt got %h exp 45", a_cnt); else n_pass++;
        n_total++; if (a_tc !== 1'b0) $display("FAIL reset_wins_tc got %b exp 0", a_tc); else n_pass++;
        a_rst_n = 1'b1; a_en = 1'b0;
    endtask

    // Borrow, digit_zero, immediate direction change and hold
    task automatic test_direction();
        a_load = 1'b1; a_init = 8'h10;
        tick();
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
        tick();
        n_total++; if (a_cnt !== 8'h09) $display("FAIL borrow_cnt got %h exp 09", a_cnt); else n_pass++;
        n_total++; if (a_dz !== 2'b10) $display("FAIL borrow_dz got %b exp 10", a_dz); else n_pass++;
        a_up = 1'b1;
        tick();
        n_total++; if (a_cnt !== 8'h10) $display("FAIL dir_up_cnt got %h exp 10", a_cnt); else n_pass++;
        n_total++; if (a_dz !== 2'b01) $display("FAIL dir_up_dz got %b exp 01", a_dz); else n_pass++;
        a_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (a_cnt !== 8'h10) $display("FAIL hold_cnt[%0d] got %h exp 10", i, a_cnt); else n_pass++;
            n_total++; if (a_tc !== 1'b0) $display("FAIL hold_tc[%0d] got %b exp 0", i, a_tc); else n_pass++;
        end
    endtask

    // Back-to-back steps with direction flips every cycle
    task automatic test_back_to_back();
        a_load = 1'b1; a_init = 8'h05;
        tick();
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
        tick();
        n_total++; if (a_cnt !== 8'h04) $display("FAIL b2b_down got %h exp 04", a_cnt); else n_pass++;
        a_up = 1'b1;
        tick();
        n_total++; if (a_cnt !== 8'h05) $display("FAIL b2b_up0 got %h exp 05", a_cnt); else n_pass++;
        tick();
        n_total++; if (a_cnt !== 8'h06) $display("FAIL b2b_up1 got %h exp 06", a_cnt); else n_pass++;
        a_en = 1'b0;
    endtask

    // Out-of-range init nibble: clamped to 9, or stored raw and zeroed on next step
    task automatic test_invalid_init();
        logic [7:0] exp_load, exp_down, exp_up;
`ifdef BCD_CNT_CLAMP_EN
        exp_load = 8'h39; exp_down = 8'h38; exp_up = 8'h40;
`else
        exp_load = 8'h3C; exp_down = 8'h30; exp_up = 8'h30;
`endif
        a_load = 1'b1; a_init = 8'h3C; a_en = 1'b0;
        tick();
        n_total++; if (a_cnt !== exp_load) $display("FAIL inv_load got %h exp %h", a_cnt, exp_load); else n_pass++;
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
        tick();
        n_total++; if (a_cnt !== exp_down) $display("FAIL inv_down got %h exp %h", a_cnt, exp_down); else n_pass++;
        a_en = 1'b0; a_rst_n = 1'b0;
        tick();
        n_total++; if (a_cnt !== exp_load) $display("FAIL inv_reset got %h exp %h", a_cnt, exp_load); else n_pass++;
        a_rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;
        tick();
        n_total++; if (a_cnt !== exp_up) $display("FAIL inv_up got %h exp %h", a_cnt, exp_up); else n_pass++;
        a_en = 1'b0;
    endtask

    initial begin
        a_rst_n = 1'b0; a_en = 1'b0; a_up = 1'b0; a_load = 1'b0; a_init = 8'h00;
        b_rst_n = 1'b0; b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_init = 12'h000;
        c_rst_n = 1'b0; c_en = 1'b0; c_up = 1'b0; c_load = 1'b0; c_init = 8'h00;
        tick();
        b_rst_n = 1'b1;
        c_rst_n = 1'b1;
        test_reset();
        test_down_wrap();
        test_up_carry();
        test_saturate();
        test_priority();
        test_direction();
        test_back_to_back();
        test_invalid_init();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
